// File: rtl/acc_micro_core.sv
// acc_micro_core -- parametrised accumulator CPU core.
//
// Fetches {opcode, imm} from instruction memory addressed by PC over a
// valid/ready handshake. It executes one instruction per accepted fetch.
// Results, PC and flags become visible on the following cycle.
// OUT parks the core in WAIT_OUT until the consumer takes out_data.
// HLT (or a stack fault) parks it in HALT until CLB is asserted.
//
// Optional feature: define MICRO_STACK_EN to enable the CALL/RET return stack.
// Without it, CALL/RET behave as NOP and err is tied low.
//
// Ports:
//   clk, CLB          clock, asynchronous active-low reset
//   INST              {opcode[3:0], imm[DATA_W-1:0]}
//   inst_valid/ready  fetch handshake (ready only in RUN)
//   PC                fetch address
//   ACC, carry, zero  accumulator and flags
//   out_data/valid    OUT port, held until out_ready
//   out_ready         consumer accepts out_data
//   halted, err       HALT state, sticky stack fault
module acc_micro_core #(
   parameter int DATA_W      = 8,
   parameter int PC_W        = 5,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              CLB,
   input  logic [DATA_W+3:0] INST,
   input  logic              inst_valid,
   output logic              inst_ready,
   output logic [PC_W-1:0]   PC,
   output logic [DATA_W-1:0] ACC,
   output logic              carry,
   output logic              zero,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              halted,
   output logic              err
);

   typedef enum logic [1:0] {S_RUN, S_WAIT_OUT, S_HALT} state_t;

   localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

   state_t              state, state_nx;
   logic [3:0]          op;
   logic [DATA_W-1:0]   imm;
   logic [DATA_W:0]     sum, dif;
   logic [PC_W-1:0]     pc_inc, pc_nx;
   logic [DATA_W-1:0]   acc_nx, od_nx;
   logic                c_nx, z_nx, ov_nx;

   assign op         = INST[DATA_W+3:DATA_W];
   assign imm        = INST[DATA_W-1:0];
   // One extra bit: for ADD it is the carry out; for SUB it is set when ACC < imm (borrow).
   assign sum        = {1'b0, ACC} + {1'b0, imm};
   assign dif        = {1'b0, ACC} - {1'b0, imm};
   assign pc_inc     = PC + PC_ONE;
   assign inst_ready = (state == S_RUN);
   assign halted     = (state == S_HALT);

`ifdef MICRO_STACK_EN
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [PC_W-1:0]  stk [STACK_DEPTH];
   logic [SP_W-1:0]  sp;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic             stk_full, stk_empty, push, pop, err_set;

   assign stk_full  = (sp == SP_W'(STACK_DEPTH));
   assign stk_empty = (sp == '0);
   assign wr_idx    = IDX_W'(sp);
   assign rd_idx    = IDX_W'(sp - SP_W'(1));

   // Stack storage needs no reset: an entry is only read after it has been pushed.
   always_ff @(posedge clk)
      if (push) stk[wr_idx] <= pc_inc;

   always_ff @(posedge clk or negedge CLB) begin
      if (!CLB) begin
         sp  <= '0;
         err <= 1'b0;
      end else begin
         if (push)     sp  <= sp + SP_W'(1);
         else if (pop) sp  <= sp - SP_W'(1);
         if (err_set)  err <= 1'b1;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^STACK_DEPTH;
   assign err        = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      pc_nx    = PC;
      acc_nx   = ACC;
      c_nx     = carry;
      z_nx     = zero;
      od_nx    = out_data;
      ov_nx    = out_valid;
`ifdef MICRO_STACK_EN
      push     = 1'b0;
      pop      = 1'b0;
      err_set  = 1'b0;
`endif
      case (state)
         S_RUN: if (inst_valid) begin
            pc_nx = pc_inc;
            case (op)
               4'h1: acc_nx = imm;
               4'h2: begin acc_nx = sum[DATA_W-1:0]; c_nx = sum[DATA_W]; end
               4'h3: begin acc_nx = dif[DATA_W-1:0]; c_nx = dif[DATA_W]; end
               4'h4: acc_nx = ACC & imm;
               4'h5: acc_nx = ACC | imm;
               4'h6: acc_nx = ACC ^ imm;
               4'h7: begin acc_nx = {ACC[DATA_W-2:0], 1'b0}; c_nx = ACC[DATA_W-1]; end
               4'h8: begin acc_nx = {1'b0, ACC[DATA_W-1:1]}; c_nx = ACC[0]; end
               4'h9: pc_nx = imm[PC_W-1:0];
               4'hA: if (zero)  pc_nx = imm[PC_W-1:0];
               4'hB: if (carry) pc_nx = imm[PC_W-1:0];
`ifdef MICRO_STACK_EN
               // A stack fault leaves PC on the faulting instruction and halts.
               4'hC: if (stk_full) begin
                  err_set  = 1'b1;
                  state_nx = S_HALT;
                  pc_nx    = PC;
               end else begin
                  push  = 1'b1;
                  pc_nx = imm[PC_W-1:0];
               end
               4'hD: if (stk_empty) begin
                  err_set  = 1'b1;
                  state_nx = S_HALT;
                  pc_nx    = PC;
               end else begin
                  pop   = 1'b1;
                  pc_nx = stk[rd_idx];
               end
`endif
               // OUT: PC advances only once the consumer accepts the data.
               4'hE: begin
                  od_nx    = ACC;
                  ov_nx    = 1'b1;
                  state_nx = S_WAIT_OUT;
                  pc_nx    = PC;
               end
               4'hF: begin
                  state_nx = S_HALT;
                  pc_nx    = PC;
               end
               default: ;
            endcase
            if (op >= 4'h1 && op <= 4'h8) z_nx = (acc_nx == '0);
         end
         S_WAIT_OUT: if (out_ready) begin
            ov_nx    = 1'b0;
            pc_nx    = pc_inc;
            state_nx = S_RUN;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge CLB) begin
      if (!CLB) begin
         state     <= S_RUN;
         PC        <= '0;
         ACC       <= '0;
         carry     <= 1'b0;
         zero      <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         PC        <= pc_nx;
         ACC       <= acc_nx;
         carry     <= c_nx;
         zero      <= z_nx;
         out_data  <= od_nx;
         out_valid <= ov_nx;
      end
   end

endmodule

// File: tb/tb_acc_micro_core.sv
`timescale 1ns/1ps
module tb_acc_micro_core;
   localparam int DW = 8, PW = 5, SD = 4;
   localparam int DMASK = (1 << DW) - 1;
   localparam int PMOD  = 1 << PW;
   localparam int RUN = 0, WAITO = 1, HALT = 2;

   logic          clk = 1'b0, CLB = 1'b1;
   logic [DW+3:0] INST = '0;
   logic          inst_valid = 1'b0, out_ready = 1'b0;
   logic          inst_ready, carry, zero, out_valid, halted, err;
   logic [PW-1:0] PC;
   logic [DW-1:0] ACC, out_data;

   acc_micro_core #(.DATA_W(DW), .PC_W(PW), .STACK_DEPTH(SD)) dut (
      .clk(clk), .CLB(CLB), .INST(INST), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .PC(PC), .ACC(ACC), .carry(carry), .zero(zero), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .halted(halted), .err(err));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [PW-1:0] pc;
      logic [DW-1:0] acc;
      logic c, z, h, e, ov;
      logic [DW-1:0] od;
      logic ir;
   } snap_t;

   snap_t exp_q[$];
   snap_t cur;
   int    vectors = 0, miscompares = 0;
   bit    mon_en = 0;
   logic  ev;

   // Reference model: architectural state as plain integers.
   int m_pc, m_acc, m_c, m_z, m_state, m_err, m_ov, m_od;
   int m_stk[$];

   function automatic snap_t m_snap();
      snap_t s;
      s.pc = PW'(m_pc); s.acc = DW'(m_acc); s.c = m_c[0]; s.z = m_z[0];
      s.h = (m_state == HALT); s.e = m_err[0]; s.ov = m_ov[0]; s.od = DW'(m_od);
      s.ir = (m_state == RUN);
      return s;
   endfunction

   function automatic snap_t dut_snap();
      snap_t s;
      s.pc = PC; s.acc = ACC; s.c = carry; s.z = zero; s.h = halted; s.e = err;
      s.ov = out_valid; s.od = out_data; s.ir = inst_ready;
      return s;
   endfunction

   task automatic chk(input string name, input snap_t a, input snap_t e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s @%0t: got pc=%h acc=%h c=%b z=%b h=%b err=%b ov=%b od=%h ir=%b ; want pc=%h acc=%h c=%b z=%b h=%b err=%b ov=%b od=%h ir=%b",
                  name, $time, a.pc, a.acc, a.c, a.z, a.h, a.e, a.ov, a.od, a.ir,
                  e.pc, e.acc, e.c, e.z, e.h, e.e, e.ov, e.od, e.ir);
      end
   endtask

   task automatic chk_v(input string name, input logic [31:0] a, input logic [31:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s @%0t: got %h want %h", name, $time, a, e);
      end
   endtask

   task automatic m_reset();
      m_pc = 0; m_acc = 0; m_c = 0; m_z = 0; m_state = RUN; m_err = 0; m_ov = 0; m_od = 0;
      m_stk.delete();
   endtask

   task automatic m_exec(input int op, input int imm);
      int nxt, r;
      nxt = (m_pc + 1) % PMOD;
      case (op)
         1:  m_acc = imm;
         2:  begin r = m_acc + imm; m_c = (r > DMASK); m_acc = r & DMASK; end
         3:  begin m_c = (m_acc < imm); m_acc = (m_acc - imm) & DMASK; end
         4:  m_acc = m_acc & imm;
         5:  m_acc = m_acc | imm;
         6:  m_acc = m_acc ^ imm;
         7:  begin m_c = (m_acc >> (DW - 1)) & 1; m_acc = (m_acc << 1) & DMASK; end
         8:  begin m_c = m_acc & 1; m_acc = m_acc >> 1; end
         9:  nxt = imm % PMOD;
         10: if (m_z != 0) nxt = imm % PMOD;
         11: if (m_c != 0) nxt = imm % PMOD;
`ifdef MICRO_STACK_EN
         12: if (m_stk.size() == SD) begin m_err = 1; m_state = HALT; nxt = m_pc; end
             else begin m_stk.push_back(nxt); nxt = imm % PMOD; end
         13: if (m_stk.size() == 0) begin m_err = 1; m_state = HALT; nxt = m_pc; end
             else nxt = m_stk.pop_back();
`endif
         14: begin m_od = m_acc; m_ov = 1; m_state = WAITO; nxt = m_pc; end
         15: begin m_state = HALT; nxt = m_pc; end
         default: ;
      endcase
      if (op >= 1 && op <= 8) m_z = (m_acc == 0);
      m_pc = nxt;
   endtask

   // Any architectural advance the DUT makes at a posedge.
   always @(posedge clk or negedge CLB)
      if (!CLB) ev <= 1'b0;
      else      ev <= (inst_valid & inst_ready) | (out_valid & out_ready);

   // Monitor: on each advance take the next expected state, then compare every cycle.
   always @(negedge clk) begin
      if (mon_en && CLB) begin
         if (ev) begin
            if (exp_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_advance @%0t: got a DUT step, want no step", $time);
            end else cur = exp_q.pop_front();
         end
         chk("state", dut_snap(), cur);
      end
   end

   task automatic step(input logic [3:0] op, input logic [DW-1:0] imm, input bit iv, input bit ordy);
      @(negedge clk); #1;
      INST = {op, imm}; inst_valid = iv; out_ready = ordy;
      if (m_state == RUN && iv) begin
         m_exec(int'(op), int'(imm));
         exp_q.push_back(m_snap());
      end else if (m_state == WAITO && ordy) begin
         m_ov = 0; m_pc = (m_pc + 1) % PMOD; m_state = RUN;
         exp_q.push_back(m_snap());
      end
   endtask

   task automatic idle(input bit ordy);
      step(4'h0, '0, 1'b0, ordy);
   endtask

   // Asserts CLB between clock edges and checks the reset values before any edge.
   task automatic do_reset();
      mon_en = 0;
      #2;
      inst_valid = 1'b0;
      CLB = 1'b0;
      #1;
      m_reset();
      exp_q.delete();
      cur = m_snap();
      chk("async_reset", dut_snap(), cur);
      @(negedge clk); #1;
      CLB = 1'b1;
      mon_en = 1;
   endtask

   initial begin
      m_reset();
      // 1: LDI/ADD/SUB to zero
      do_reset();
      step(4'h1, 8'h05, 1, 1); step(4'h2, 8'h03, 1, 1); step(4'h3, 8'h08, 1, 1); idle(1);
      chk_v("t1_acc", ACC, 0); chk_v("t1_z", zero, 1); chk_v("t1_c", carry, 0); chk_v("t1_pc", PC, 3);
      // 2: carry, branches, PC wrap
      do_reset();
      step(4'h1, 8'hFF, 1, 1); step(4'h2, 8'h01, 1, 1); step(4'hB, 8'h10, 1, 1); idle(1);
      chk_v("t2_pc_jc", PC, 5'h10); chk_v("t2_c", carry, 1);
      step(4'hA, 8'h1F, 1, 1); step(4'h0, 8'h00, 1, 1); idle(1);
      chk_v("t2_pc_wrap", PC, 0);
      // 3: OUT with back-pressure
      do_reset();
      step(4'h1, 8'hA5, 1, 1); step(4'hE, 8'h00, 1, 0);
      repeat (3) step(4'h1, 8'h77, 1, 0);
      chk_v("t3_ov", out_valid, 1); chk_v("t3_od", out_data, 8'hA5);
      chk_v("t3_ir", inst_ready, 0); chk_v("t3_pc", PC, 1);
      step(4'h1, 8'h77, 1, 1); idle(1);
      chk_v("t3_ov_drop", out_valid, 0); chk_v("t3_pc_adv", PC, 2);
      // 4: fetch gaps
      do_reset();
      step(4'h1, 8'h11, 1, 1); step(4'h2, 8'h55, 0, 1); step(4'h2, 8'h55, 0, 1);
      step(4'h2, 8'h22, 1, 1); idle(1);
      chk_v("t4_acc", ACC, 8'h33); chk_v("t4_pc", PC, 2);
      // 5: CALL/RET and stack overflow
      do_reset();
      repeat (4) step(4'h0, 8'h00, 1, 1);
      step(4'hC, 8'h14, 1, 1); step(4'hD, 8'h00, 1, 1);
      for (int i = 0; i < 5; i++) step(4'hC, 8'(8 + i), 1, 1);
      idle(1); idle(1);
      chk_v("t5_err", err, m_err); chk_v("t5_halt", halted, m_state == HALT);
      // 6: HLT, then reset during WAIT_OUT
      do_reset();
      step(4'hF, 8'h00, 1, 1);
      repeat (4) step(4'h1, 8'h3C, 1, 1);
      chk_v("t6_halted", halted, 1); chk_v("t6_ir", inst_ready, 0); chk_v("t6_pc", PC, 0);
      do_reset();
      step(4'h1, 8'h5A, 1, 1); step(4'hE, 8'h00, 1, 0); idle(0); idle(0);
      chk_v("t6_wait_ov", out_valid, 1);
      do_reset();
      // Random programs against the model
      for (int r = 0; r < 20; r++) begin
         do_reset();
         for (int k = 0; k < 150; k++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 9) != 0) op = 4'h0;
            step(op, 8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
         end
      end
      idle(1); idle(1);
      chk_v("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
